// File: rtl/board_loader.sv
// Collects a 64-square position from a serial piece stream into a shadow buffer
// and presents it to the engine, holding it until the engine reports done.
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef EMPTY_POSN
`define EMPTY_POSN 4'h0
`endif

module board_loader #(
    parameter int PIECE_WIDTH = `PIECE_BITS,
    parameter int SIDE_WIDTH  = PIECE_WIDTH * 8,
    parameter int BOARD_WIDTH = PIECE_WIDTH * 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PIECE_WIDTH-1:0] piece_in,
    input  logic                   piece_valid,
    input  logic                   piece_last,
    input  logic                   wtm_in,
    output logic                   piece_ready,
    output logic [BOARD_WIDTH-1:0] board,
    output logic                   board_valid,
    output logic                   white_to_move,
    input  logic                   is_attacking_done,
    output logic                   frame_error
);

    localparam logic [PIECE_WIDTH-1:0] EMPTY = PIECE_WIDTH'(`EMPTY_POSN);
    localparam logic [BOARD_WIDTH-1:0] EMPTY_BOARD = {64{EMPTY}};

    typedef enum logic [1:0] {
        LOAD,
        PRESENT,
        WAIT_DONE
    } state_t;

    state_t                 state;
    logic [5:0]             index;
    logic [BOARD_WIDTH-1:0] shadow;
    logic [BOARD_WIDTH-1:0] shadow_final;
    logic                   beat_accept;
    logic                   at_last_sq;
    int unsigned            wr_offset;

    assign beat_accept = piece_valid && piece_ready;
    assign at_last_sq  = (index == 6'd63);
    assign wr_offset   = int'(index[5:3]) * SIDE_WIDTH + int'(index[2:0]) * PIECE_WIDTH;

    // Shadow with square 63 already merged, so the completing beat can load board directly.
    always_comb begin
        shadow_final = shadow;
        shadow_final[BOARD_WIDTH-PIECE_WIDTH +: PIECE_WIDTH] = piece_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= LOAD;
            index         <= '0;
            shadow        <= EMPTY_BOARD;
            board         <= EMPTY_BOARD;
            board_valid   <= 1'b0;
            white_to_move <= 1'b1;
            piece_ready   <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            board_valid <= 1'b0;
            frame_error <= 1'b0;
            unique case (state)
                LOAD: begin
                    piece_ready <= 1'b1;
                    if (beat_accept) begin
                        if (piece_last && at_last_sq) begin
                            // Board is registered on the completing edge so it is
                            // visible during the PRESENT cycle together with board_valid.
                            shadow        <= shadow_final;
                            board         <= shadow_final;
                            white_to_move <= wtm_in;
                            board_valid   <= 1'b1;
                            piece_ready   <= 1'b0;
                            index         <= '0;
                            state         <= PRESENT;
                        end else if (piece_last || at_last_sq) begin
                            frame_error <= 1'b1;
                            index       <= '0;
                        end else begin
                            shadow[wr_offset +: PIECE_WIDTH] <= piece_in;
                            index <= index + 6'd1;
                        end
                    end
                end
                PRESENT: begin
                    piece_ready <= 1'b0;
                    state       <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (is_attacking_done) begin
                        piece_ready <= 1'b1;
                        state       <= LOAD;
                    end
                end
                default: begin
                    piece_ready <= 1'b0;
                    state       <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_loader.sv
// Directed, table-driven bench for board_loader: framing, presentation,
// done handshake, framing errors and asynchronous reset mid-frame.
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef EMPTY_POSN
`define EMPTY_POSN 4'h0
`endif
`ifndef WHITE_PAWN
`define WHITE_PAWN 4'h1
`endif
`ifndef WHITE_QUEEN
`define WHITE_QUEEN 4'h5
`endif
`ifndef WHITE_KING
`define WHITE_KING 4'h6
`endif
`ifndef BLACK_PAWN
`define BLACK_PAWN 4'h9
`endif
`ifndef BLACK_ROOK
`define BLACK_ROOK 4'hC
`endif
`ifndef BLACK_QUEEN
`define BLACK_QUEEN 4'hD
`endif
`ifndef BLACK_KING
`define BLACK_KING 4'hE
`endif

module tb_board_loader;

    localparam int PW = `PIECE_BITS;
    localparam int BW = PW * 64;
    localparam logic [PW-1:0] EMPTY       = PW'(`EMPTY_POSN);
    localparam logic [PW-1:0] WHITE_PAWN  = PW'(`WHITE_PAWN);
    localparam logic [PW-1:0] WHITE_QUEEN = PW'(`WHITE_QUEEN);
    localparam logic [PW-1:0] WHITE_KING  = PW'(`WHITE_KING);
    localparam logic [PW-1:0] BLACK_PAWN  = PW'(`BLACK_PAWN);
    localparam logic [PW-1:0] BLACK_ROOK  = PW'(`BLACK_ROOK);
    localparam logic [PW-1:0] BLACK_QUEEN = PW'(`BLACK_QUEEN);
    localparam logic [PW-1:0] BLACK_KING  = PW'(`BLACK_KING);

    logic          clk;
    logic          reset;
    logic [PW-1:0] piece_in;
    logic          piece_valid;
    logic          piece_last;
    logic          wtm_in;
    logic          piece_ready;
    logic [BW-1:0] board;
    logic          board_valid;
    logic          white_to_move;
    logic          is_attacking_done;
    logic          frame_error;

    board_loader #(.PIECE_WIDTH(PW)) dut (
        .clk               (clk),
        .reset             (reset),
        .piece_in          (piece_in),
        .piece_valid       (piece_valid),
        .piece_last        (piece_last),
        .wtm_in            (wtm_in),
        .piece_ready       (piece_ready),
        .board             (board),
        .board_valid       (board_valid),
        .white_to_move     (white_to_move),
        .is_attacking_done (is_attacking_done),
        .frame_error       (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            sq_a;
        logic [PW-1:0] pc_a;
        int            sq_b;
        logic [PW-1:0] pc_b;
        logic          wtm;
        bit            gaps;
        logic [PW-1:0] exp_a;
        logic [PW-1:0] exp_b;
        logic          exp_wtm;
    } vec_t;

    vec_t          vecs [4];
    logic [PW-1:0] frame [64];
    logic [BW-1:0] exp_board;
    logic [BW-1:0] empty_board;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] model_board();
        logic [BW-1:0] m;
        for (int s = 0; s < 64; s++) m[s*PW +: PW] = frame[s];
        return m;
    endfunction

    task automatic fill_frame(input int sq_a, input logic [PW-1:0] pa,
                              input int sq_b, input logic [PW-1:0] pb);
        for (int s = 0; s < 64; s++) frame[s] = EMPTY;
        frame[sq_a] = pa;
        frame[sq_b] = pb;
    endtask

    // Offer one beat and return #1 after the edge that accepts it.
    task automatic send_beat(input logic [PW-1:0] p, input logic last, input logic w);
        int n = 0;
        piece_in    = p;
        piece_valid = 1'b1;
        piece_last  = last;
        wtm_in      = w;
        while (piece_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_for_beat", BW'(piece_ready), BW'(1'b1));
        @(posedge clk); #1;
        piece_valid = 1'b0;
        piece_last  = 1'b0;
    endtask

    task automatic send_frame(input logic w, input bit gaps);
        for (int s = 0; s < 64; s++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                piece_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
            send_beat(frame[s], s == 63, w);
        end
    endtask

    // Called #1 after the accepting edge of the last beat (the PRESENT cycle).
    task automatic present_and_release(input logic exp_wtm);
        exp_board = model_board();
        check("bv_present", BW'(board_valid), BW'(1'b1));
        check("board_present", board, exp_board);
        check("wtm_present", BW'(white_to_move), BW'(exp_wtm));
        check("ready_present", BW'(piece_ready), BW'(1'b0));
        // Done during PRESENT must be ignored; junk beat held during WAIT_DONE.
        is_attacking_done = 1'b1;
        piece_valid = 1'b1;
        piece_last  = 1'b1;
        piece_in    = WHITE_KING;
        @(posedge clk); #1;
        is_attacking_done = 1'b0;
        check("bv_one_cycle", BW'(board_valid), BW'(1'b0));
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("ready_wait", BW'(piece_ready), BW'(1'b0));
            check("board_stable", board, exp_board);
        end
        piece_valid = 1'b0;
        piece_last  = 1'b0;
        is_attacking_done = 1'b1;
        @(posedge clk); #1;
        is_attacking_done = 1'b0;
        check("ready_after_done", BW'(piece_ready), BW'(1'b1));
        check("board_after_done", board, exp_board);
        check("wtm_after_done", BW'(white_to_move), BW'(exp_wtm));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{36, BLACK_ROOK, 28, BLACK_PAWN, 1'b0, 1'b0, BLACK_ROOK, BLACK_PAWN, 1'b0};
        vecs[1] = '{0, WHITE_KING, 63, BLACK_KING, 1'b1, 1'b1, WHITE_KING, BLACK_KING, 1'b1};
        vecs[2] = '{7, WHITE_QUEEN, 56, BLACK_QUEEN, 1'b0, 1'b1, WHITE_QUEEN, BLACK_QUEEN, 1'b0};
        vecs[3] = '{1, WHITE_PAWN, 62, BLACK_PAWN, 1'b1, 1'b0, WHITE_PAWN, BLACK_PAWN, 1'b1};
        for (int s = 0; s < 64; s++) empty_board[s*PW +: PW] = EMPTY;

        reset = 1'b0;
        piece_in = EMPTY;
        piece_valid = 1'b0;
        piece_last = 1'b0;
        wtm_in = 1'b1;
        is_attacking_done = 1'b0;

        repeat (4) begin
            @(posedge clk); #1;
            check("rst_ready", BW'(piece_ready), BW'(1'b0));
        end
        check("rst_board", board, empty_board);
        check("rst_bv", BW'(board_valid), BW'(1'b0));
        check("rst_wtm", BW'(white_to_move), BW'(1'b1));
        check("rst_ferr", BW'(frame_error), BW'(1'b0));
        reset = 1'b1;
        #1;
        check("ready_at_release", BW'(piece_ready), BW'(1'b0));
        @(posedge clk); #1;
        check("ready_after_release", BW'(piece_ready), BW'(1'b1));

        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                // Early piece_last on beat 10.
                exp_board = board;
                for (int s = 0; s <= 10; s++) send_beat(WHITE_PAWN, s == 10, 1'b1);
                check("ferr_early_last", BW'(frame_error), BW'(1'b1));
                check("ferr_no_bv", BW'(board_valid), BW'(1'b0));
                check("ferr_board_kept", board, exp_board);
                @(posedge clk); #1;
                check("ferr_one_cycle", BW'(frame_error), BW'(1'b0));
                check("ferr_no_bv_next", BW'(board_valid), BW'(1'b0));
                // Square 63 reached without piece_last.
                for (int s = 0; s < 64; s++) send_beat(WHITE_PAWN, 1'b0, 1'b1);
                check("ferr_missing_last", BW'(frame_error), BW'(1'b1));
                check("ferr2_no_bv", BW'(board_valid), BW'(1'b0));
                check("ferr2_board_kept", board, exp_board);
            end
            fill_frame(vecs[i].sq_a, vecs[i].pc_a, vecs[i].sq_b, vecs[i].pc_b);
            send_frame(vecs[i].wtm, vecs[i].gaps);
            check("sq_a", BW'(board[vecs[i].sq_a*PW +: PW]), BW'(vecs[i].exp_a));
            check("sq_b", BW'(board[vecs[i].sq_b*PW +: PW]), BW'(vecs[i].exp_b));
            present_and_release(vecs[i].exp_wtm);
        end

        // Reset at beat 30 of a frame full of pawns.
        for (int s = 0; s < 30; s++) send_beat(WHITE_PAWN, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_board", board, empty_board);
        check("midrst_ready", BW'(piece_ready), BW'(1'b0));
        check("midrst_wtm", BW'(white_to_move), BW'(1'b1));
        check("midrst_bv", BW'(board_valid), BW'(1'b0));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        fill_frame(5, BLACK_ROOK, 40, WHITE_QUEEN);
        send_frame(1'b0, 1'b0);
        check("post_rst_sq0", BW'(board[0 +: PW]), BW'(EMPTY));
        check("post_rst_sq5", BW'(board[5*PW +: PW]), BW'(BLACK_ROOK));
        present_and_release(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_loader.md
# board_loader

Assembles a chess position from a serial stream of piece codes and presents it to the move/attack engine. It drives the `board`, `board_valid` and `white_to_move` inputs of `vchess`, and the `board` input of `display_board`. It holds the presented board stable until the engine returns `is_attacking_done`, then accepts the next position. Positions arrive from a host-side byte/word path, one square per beat, with valid/ready handshaking.

## Interface

Parameters:
- PIECE_WIDTH, `PIECE_BITS: width of one piece code.
- SIDE_WIDTH, PIECE_WIDTH*8: width of one rank.
- BOARD_WIDTH, PIECE_WIDTH*64: width of the full board vector.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; a low level resets all state immediately.
- piece_in  in  PIECE_WIDTH  piece code for the current square.
- piece_valid  in  1  piece_in is valid this cycle.
- piece_last  in  1  marks the final beat of a frame (square 63); qualified by piece_valid.
- wtm_in  in  1  side to move; sampled on the accepted last beat.
- piece_ready  out  1  loader accepts a beat this cycle.
- board  out  BOARD_WIDTH  presented position; square s at [s*PIECE_WIDTH +: PIECE_WIDTH], s = rank*8 + file.
- board_valid  out  1  one-cycle pulse: board/white_to_move are new and valid.
- white_to_move  out  1  side to move for the presented board.
- is_attacking_done  in  1  engine finished with the presented board.
- frame_error  out  1  one-cycle pulse on a malformed frame.

## Operation

- Beat accept = piece_valid && piece_ready. Beats fill squares 0..63 in order into a shadow buffer.
- A 6-bit square index counts the beats. It clears on reset, on frame completion and on frame error.
- `board` is written only from the shadow buffer, and only on the cycle board_valid asserts. It is never partially updated.
- FSM states:
  - LOAD: piece_ready=1.
    - Accepted beat with index<63 and !piece_last: store the beat, index+1.
    - Accepted beat with index==63 and piece_last: store the beat, latch wtm_in, go to PRESENT.
    - Accepted beat with piece_last and index!=63, or index==63 without piece_last: pulse frame_error, discard the shadow contents, index=0, stay in LOAD. board is unchanged.
  - PRESENT (1 cycle): copy shadow to board, drive white_to_move from the latched wtm_in, board_valid=1, piece_ready=0. Always go to WAIT_DONE.
  - WAIT_DONE: piece_ready=0. When is_attacking_done=1, go to LOAD. board and white_to_move stay stable throughout this state.
- is_attacking_done is ignored in LOAD and PRESENT.
- The shadow buffer is not cleared between frames. Every frame overwrites all 64 entries.
- Reset values:
  - board: all squares `EMPTY_POSN
  - board_valid: 0
  - white_to_move: 1
  - piece_ready: 0
  - frame_error: 0
  - FSM: LOAD, index 0
- piece_ready is registered. It first rises on the first clock edge after reset is released.
- Reset asserted mid-frame or in WAIT_DONE aborts all activity. The partial frame is lost and outputs take their reset values immediately.

## Timing

- Accepted last beat at edge N → PRESENT after N. board, white_to_move and board_valid=1 are visible in cycle N+1. board_valid drops after edge N+1.
- piece_ready is 0 from cycle N+1 until the state returns to LOAD.
- is_attacking_done=1 sampled at edge M in WAIT_DONE → piece_ready=1 in cycle M+1.
- Minimum frame period: 64 beats + 1 PRESENT cycle + engine latency + 1 cycle.
- frame_error is high for exactly the cycle after the offending accepted beat.
- A beat offered in the cycle piece_ready returns to 1 is accepted.

## Test plan

- Reset: hold reset=0 for 4 cycles, then release. Required: board all `EMPTY_POSN, board_valid=0, white_to_move=1, frame_error=0; piece_ready=0 during reset and 1 one cycle after release.
- Nominal load: stream 64 beats, all EMPTY except square 36=`BLACK_ROOK and square 28=`BLACK_PAWN; wtm_in=0 on the last beat. Required: board_valid high for exactly one cycle, the cycle after the last beat; board matches those values at bits 36*PW and 28*PW; white_to_move=0.
- Done handshake: pulse is_attacking_done during PRESENT and again 20 cycles into WAIT_DONE. Required: the first pulse is ignored; piece_ready rises the cycle after the second; board stays constant throughout.
- Framing error: assert piece_last on beat 10. Required: frame_error pulses once, board is unchanged, no board_valid. A following clean 64-beat frame presents correctly.
- Backpressure/gaps: random piece_valid gaps during load, and piece_valid held high during WAIT_DONE. Required: no beats are accepted in WAIT_DONE; the board is assembled in square order regardless of gaps.
- Reset mid-operation: drop reset at beat 30, release, then send a full frame. Required: outputs at reset values immediately; the new frame presents with no data from the aborted frame.
